// File: rtl/asps_pkg.sv
// Shared types and default sizing for the parking lot controller.
package asps_pkg;

  typedef enum logic [1:0] {
    WAIT_CLEAR,
    IDLE,
    QUALIFY,
    PRESENT
  } gate_state_t;

  localparam int DEF_SLOTS    = 4;
  localparam int DEF_ID_W     = 2;
  localparam int DEF_TIME_W   = 8;
  localparam int DEF_COST_W   = 8;
  localparam int DEF_RATE     = 1;
  localparam int DEF_TICK_DIV = 1;
  localparam int DEF_DEBOUNCE = 2;

endpackage

// File: rtl/asps_gate_debounce.sv
// Gate sensor qualifier: a car counts once DEBOUNCE consecutive low samples are seen,
// and the gate must go clear again before the next car can be detected.
module asps_gate_debounce
  import asps_pkg::*;
#(
  parameter int DEBOUNCE = DEF_DEBOUNCE
) (
  input  logic clk,
  input  logic reset,
  input  logic ir,
  output logic detect
);

  localparam int CNT_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

  gate_state_t      state;
  logic [CNT_W-1:0] low_cnt;

  // Starting in WAIT_CLEAR means a sensor already blocked at reset release is ignored.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= WAIT_CLEAR;
      low_cnt <= '0;
      detect  <= 1'b0;
    end else begin
      detect <= 1'b0;
      case (state)
        WAIT_CLEAR: if (ir) state <= IDLE;
        IDLE: begin
          if (!ir) begin
            if (DEBOUNCE == 1) begin
              state  <= PRESENT;
              detect <= 1'b1;
            end else begin
              state   <= QUALIFY;
              low_cnt <= CNT_W'(1);
            end
          end
        end
        QUALIFY: begin
          if (ir) begin
            state <= IDLE;
          end else if (low_cnt == CNT_W'(DEBOUNCE - 1)) begin
            state  <= PRESENT;
            detect <= 1'b1;
          end else begin
            low_cnt <= low_cnt + CNT_W'(1);
          end
        end
        PRESENT: if (ir) state <= IDLE;
        default: state <= WAIT_CLEAR;
      endcase
    end
  end

endmodule

// File: rtl/asps_lot_controller.sv
// Parking lot controller: tracks per-ID occupancy and entry time stamps,
// and reports a saturated parking cost when a parked car leaves.
module asps_lot_controller
  import asps_pkg::*;
#(
  parameter int SLOTS    = DEF_SLOTS,
  parameter int ID_W     = DEF_ID_W,
  parameter int TIME_W   = DEF_TIME_W,
  parameter int COST_W   = DEF_COST_W,
  parameter int RATE     = DEF_RATE,
  parameter int TICK_DIV = DEF_TICK_DIV,
  parameter int DEBOUNCE = DEF_DEBOUNCE
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              IR_entry,
  input  logic              IR_exit,
  input  logic [ID_W-1:0]   entry_id,
  input  logic [ID_W-1:0]   exit_id,
  output logic [ID_W:0]     car_count,
  output logic [SLOTS-1:0]  occupancy,
  output logic              empty_flag,
  output logic              full_flag,
  output logic              entry_detected,
  output logic              exit_detected,
  output logic              entry_reject,
  output logic              exit_reject,
  output logic [COST_W-1:0] cost,
  output logic              cost_valid,
  output logic [TIME_W-1:0] current_time_out
);

  localparam int CNT_W  = ID_W + 1;
  localparam int PRE_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int PROD_W = TIME_W + COST_W + 32;

  logic [PRE_W-1:0]  prescale;
  logic [TIME_W-1:0] now;
  logic [TIME_W-1:0] stamp [SLOTS];

  logic              exit_ok;
  logic              entry_ok;
  logic [SLOTS-1:0]  occ_after_exit;
  logic [SLOTS-1:0]  next_occ;
  logic [CNT_W-1:0]  count_after_exit;
  logic [CNT_W-1:0]  next_count;
  logic [TIME_W-1:0] elapsed;
  logic [PROD_W-1:0] product;
  logic [PROD_W-1:0] cost_max;
  logic [COST_W-1:0] next_cost;

  always_ff @(posedge clk) begin
    if (!reset) begin
      prescale <= '0;
      now      <= '0;
    end else if (prescale == PRE_W'(TICK_DIV - 1)) begin
      prescale <= '0;
      now      <= now + TIME_W'(1);
    end else begin
      prescale <= prescale + PRE_W'(1);
    end
  end

  assign current_time_out = now;

  asps_gate_debounce #(.DEBOUNCE(DEBOUNCE)) u_entry_gate (
    .clk    (clk),
    .reset  (reset),
    .ir     (IR_entry),
    .detect (entry_detected)
  );

  asps_gate_debounce #(.DEBOUNCE(DEBOUNCE)) u_exit_gate (
    .clk    (clk),
    .reset  (reset),
    .ir     (IR_exit),
    .detect (exit_detected)
  );

  // Exit is resolved first so a full lot, or the same ID leaving and re-entering, can admit the entry.
  always_comb begin
    exit_ok          = exit_detected && occupancy[exit_id];
    occ_after_exit   = occupancy;
    if (exit_ok) occ_after_exit[exit_id] = 1'b0;
    count_after_exit = car_count - CNT_W'(exit_ok);
    entry_ok         = entry_detected && !occ_after_exit[entry_id] &&
                       (count_after_exit < CNT_W'(SLOTS));
    next_occ         = occ_after_exit;
    if (entry_ok) next_occ[entry_id] = 1'b1;
    next_count       = count_after_exit + CNT_W'(entry_ok);
    elapsed          = now - stamp[exit_id];
    product          = PROD_W'(elapsed) * PROD_W'(RATE);
    cost_max         = {{(PROD_W - COST_W){1'b0}}, {COST_W{1'b1}}};
    next_cost        = (product > cost_max) ? {COST_W{1'b1}} : product[COST_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      occupancy    <= '0;
      car_count    <= '0;
      empty_flag   <= 1'b1;
      full_flag    <= 1'b0;
      entry_reject <= 1'b0;
      exit_reject  <= 1'b0;
      cost         <= '0;
      cost_valid   <= 1'b0;
      for (int i = 0; i < SLOTS; i++) stamp[i] <= '0;
    end else begin
      occupancy    <= next_occ;
      car_count    <= next_count;
      empty_flag   <= (next_count == '0);
      full_flag    <= (next_count == CNT_W'(SLOTS));
      entry_reject <= entry_detected && !entry_ok;
      exit_reject  <= exit_detected && !exit_ok;
      cost_valid   <= exit_ok;
      if (exit_ok) cost <= next_cost;
      if (entry_ok) stamp[entry_id] <= now;
    end
  end

endmodule

// File: tb/tb_asps_lot_controller.sv
// Scoreboard bench for the parking lot controller: stimulus queues expected
// gate responses, a monitor pops and compares them the cycle after each detect.
module tb_asps_lot_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       IR_entry = 1'b1;
  logic       IR_exit = 1'b1;
  logic [1:0] entry_id = 2'd0;
  logic [1:0] exit_id = 2'd0;
  logic [2:0] car_count;
  logic [3:0] occupancy;
  logic       empty_flag, full_flag;
  logic       entry_detected, exit_detected, entry_reject, exit_reject;
  logic [7:0] cost;
  logic       cost_valid;
  logic [7:0] current_time_out;

  logic       IR_entry2 = 1'b1;
  logic       IR_exit2 = 1'b1;
  logic [2:0] car_count2;
  logic [3:0] occupancy2;
  logic       empty_flag2, full_flag2;
  logic       entry_detected2, exit_detected2, entry_reject2, exit_reject2;
  logic [7:0] cost2;
  logic       cost_valid2;
  logic [7:0] current_time_out2;

  always #5 clk = ~clk;

  asps_lot_controller #(
    .SLOTS(4), .ID_W(2), .TIME_W(8), .COST_W(8), .RATE(1), .TICK_DIV(1), .DEBOUNCE(2)
  ) dut (
    .clk(clk), .reset(reset), .IR_entry(IR_entry), .IR_exit(IR_exit),
    .entry_id(entry_id), .exit_id(exit_id), .car_count(car_count), .occupancy(occupancy),
    .empty_flag(empty_flag), .full_flag(full_flag), .entry_detected(entry_detected),
    .exit_detected(exit_detected), .entry_reject(entry_reject), .exit_reject(exit_reject),
    .cost(cost), .cost_valid(cost_valid), .current_time_out(current_time_out)
  );

  asps_lot_controller #(
    .SLOTS(4), .ID_W(2), .TIME_W(8), .COST_W(8), .RATE(40), .TICK_DIV(1), .DEBOUNCE(2)
  ) dut_rate40 (
    .clk(clk), .reset(reset), .IR_entry(IR_entry2), .IR_exit(IR_exit2),
    .entry_id(2'd0), .exit_id(2'd0), .car_count(car_count2), .occupancy(occupancy2),
    .empty_flag(empty_flag2), .full_flag(full_flag2), .entry_detected(entry_detected2),
    .exit_detected(exit_detected2), .entry_reject(entry_reject2), .exit_reject(exit_reject2),
    .cost(cost2), .cost_valid(cost_valid2), .current_time_out(current_time_out2)
  );

  // Independent model of the global time counter (TICK_DIV = 1).
  logic [7:0] tb_time = 8'd0;
  always @(posedge clk) begin
    if (!reset) tb_time <= 8'd0;
    else        tb_time <= tb_time + 8'd1;
  end

  typedef struct {
    string      name;
    logic       ent_rej;
    logic       ex_rej;
    logic       cv;
    logic [7:0] cost;
    logic [2:0] count;
    logic [3:0] occ;
  } exp_t;

  exp_t sb_q[$];
  int n_vec = 0;
  int n_miss = 0;
  int exp_entry_det = 0, exp_exit_det = 0, exp_cv = 0;
  int seen_entry_det = 0, seen_exit_det = 0, seen_cv = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_vec++;
    if (actual !== expected) begin
      n_miss++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Monitor: the cycle after any detect pulse, pop one expected response and compare.
  initial begin
    logic pend;
    exp_t e;
    pend = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        if (pend) begin
          n_vec++;
          if (sb_q.size() == 0) begin
            n_miss++;
            $display("[TB] FAIL unexpected_response: detect pulse with no queued expectation");
          end else begin
            e = sb_q.pop_front();
            if ({entry_reject, exit_reject, cost_valid, cost, car_count, occupancy, full_flag, empty_flag} !==
                {e.ent_rej, e.ex_rej, e.cv, e.cost, e.count, e.occ, (e.count == 3'd4), (e.count == 3'd0)}) begin
              n_miss++;
              $display("[TB] FAIL %s: got rej=%b/%b cv=%b cost=%0d count=%0d occ=%b full=%b empty=%b, expected rej=%b/%b cv=%b cost=%0d count=%0d occ=%b full=%b empty=%b",
                       e.name, entry_reject, exit_reject, cost_valid, cost, car_count, occupancy, full_flag, empty_flag,
                       e.ent_rej, e.ex_rej, e.cv, e.cost, e.count, e.occ, (e.count == 3'd4), (e.count == 3'd0));
            end
          end
        end else if (entry_reject || exit_reject || cost_valid) begin
          n_vec++;
          n_miss++;
          $display("[TB] FAIL spurious_pulse: got rej=%b/%b cv=%b, expected none", entry_reject, exit_reject, cost_valid);
        end
        if (entry_detected) seen_entry_det++;
        if (exit_detected)  seen_exit_det++;
        if (cost_valid)     seen_cv++;
        pend = entry_detected || exit_detected;
      end else begin
        pend = 1'b0;
      end
    end
  end

  task automatic wait_time(input logic [7:0] t);
    int guard;
    guard = 0;
    while (tb_time != t && guard < 300) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 300) begin
      n_vec++;
      n_miss++;
      $display("[TB] FAIL wait_time: got time %0d, expected %0d within 300 cycles", tb_time, t);
    end
  endtask

  // Drop the selected sensors so the detect cycle lands exactly at time t.
  task automatic applyStimulus(input string name, input logic do_en, input logic [1:0] eid,
                               input logic do_ex, input logic [1:0] xid, input logic [7:0] t,
                               input logic ent_rej, input logic ex_rej, input logic cv,
                               input logic [7:0] ecost, input logic [2:0] ecount, input logic [3:0] eocc);
    exp_t e;
    wait_time(t - 8'd2);
    e.name = name; e.ent_rej = ent_rej; e.ex_rej = ex_rej; e.cv = cv;
    e.cost = ecost; e.count = ecount; e.occ = eocc;
    sb_q.push_back(e);
    if (do_en) exp_entry_det++;
    if (do_ex) exp_exit_det++;
    if (cv)    exp_cv++;
    entry_id = eid;
    exit_id  = xid;
    if (do_en) IR_entry = 1'b0;
    if (do_ex) IR_exit = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    IR_entry = 1'b1;
    IR_exit  = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int guard;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_count", 32'(car_count), 32'd0);
    checkOutput("reset_occ", 32'(occupancy), 32'd0);
    checkOutput("reset_flags", 32'({empty_flag, full_flag}), 32'b10);
    checkOutput("reset_cost", 32'(cost), 32'd0);
    checkOutput("reset_time", 32'(current_time_out), 32'd0);
    checkOutput("reset_pulses", 32'({entry_detected, exit_detected, entry_reject, exit_reject, cost_valid}), 32'd0);
    reset = 1'b1;

    applyStimulus("entry1_t5",  1, 2'd1, 0, 2'd0, 8'd5,  0, 0, 0, 8'd0,  3'd1, 4'b0010);
    applyStimulus("exit1_t17",  0, 2'd0, 1, 2'd1, 8'd17, 0, 0, 1, 8'd12, 3'd0, 4'b0000);
    checkOutput("time_track", 32'(current_time_out), 32'(tb_time));

    wait_time(8'd20);
    exit_id = 2'd2;
    IR_exit = 1'b0;
    @(posedge clk); #1;
    IR_exit = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
    end

    applyStimulus("exit_unparked3", 0, 2'd0, 1, 2'd3, 8'd30, 0, 1, 0, 8'd12, 3'd0, 4'b0000);
    applyStimulus("fill_id0", 1, 2'd0, 0, 2'd0, 8'd40, 0, 0, 0, 8'd12, 3'd1, 4'b0001);
    applyStimulus("fill_id1", 1, 2'd1, 0, 2'd0, 8'd45, 0, 0, 0, 8'd12, 3'd2, 4'b0011);
    applyStimulus("fill_id2", 1, 2'd2, 0, 2'd0, 8'd50, 0, 0, 0, 8'd12, 3'd3, 4'b0111);
    applyStimulus("fill_id3", 1, 2'd3, 0, 2'd0, 8'd55, 0, 0, 0, 8'd12, 3'd4, 4'b1111);
    applyStimulus("full_reject", 1, 2'd0, 0, 2'd0, 8'd60, 1, 0, 0, 8'd12, 3'd4, 4'b1111);
    applyStimulus("simul_id2", 1, 2'd2, 1, 2'd2, 8'd70, 0, 0, 1, 8'd20, 3'd4, 4'b1111);
    applyStimulus("restamp_exit2", 0, 2'd0, 1, 2'd2, 8'd80, 0, 0, 1, 8'd10, 3'd3, 4'b1011);
    applyStimulus("dup_entry0", 1, 2'd0, 0, 2'd0, 8'd85, 1, 0, 0, 8'd10, 3'd3, 4'b1011);
    applyStimulus("exit3_t100", 0, 2'd0, 1, 2'd3, 8'd100, 0, 0, 1, 8'd45, 3'd2, 4'b0011);
    applyStimulus("entry3_t250", 1, 2'd3, 0, 2'd0, 8'd250, 0, 0, 0, 8'd45, 3'd3, 4'b1011);
    applyStimulus("wrap_exit3", 0, 2'd0, 1, 2'd3, 8'd4, 0, 0, 1, 8'd10, 3'd2, 4'b0011);

    wait_time(8'd18);
    IR_entry2 = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    IR_entry2 = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
    end
    checkOutput("rate40_count_in", 32'(car_count2), 32'd1);
    wait_time(8'd28);
    IR_exit2 = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    IR_exit2 = 1'b1;
    guard = 0;
    while (!cost_valid2 && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    if (!cost_valid2) begin
      n_vec++;
      n_miss++;
      $display("[TB] FAIL rate40_cost_valid: got no cost_valid, expected one within 10 cycles");
    end else begin
      checkOutput("rate40_saturated_cost", 32'(cost2), 32'd255);
    end
    checkOutput("rate40_count_out", 32'(car_count2), 32'd0);

    @(posedge clk); #1;
    IR_entry = 1'b0;
    entry_id = 2'd2;
    reset = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    checkOutput("midstay_reset_count", 32'(car_count), 32'd0);
    checkOutput("midstay_reset_occ", 32'(occupancy), 32'd0);
    checkOutput("midstay_reset_cost", 32'(cost), 32'd0);
    reset = 1'b1;
    repeat (6) begin
      @(posedge clk); #1;
    end
    checkOutput("held_low_no_detect", 32'(seen_entry_det), 32'(exp_entry_det));
    IR_entry = 1'b1;
    applyStimulus("entry2_after_reset", 1, 2'd2, 0, 2'd0, 8'd12, 0, 0, 0, 8'd0, 3'd1, 4'b0100);

    repeat (5) @(posedge clk);
    #1;
    checkOutput("entry_detect_total", 32'(seen_entry_det), 32'(exp_entry_det));
    checkOutput("exit_detect_total", 32'(seen_exit_det), 32'(exp_exit_det));
    checkOutput("cost_valid_total", 32'(seen_cv), 32'(exp_cv));
    checkOutput("queue_drained", 32'(sb_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
